vector_list_player: RTL

Display-list sequencer: the command source for the vector control block. Fetches 32-bit vector commands from a synchronous display-list RAM. Presents them on the `x`/`y`/`jump`/`draw` inputs of the control block, honouring its `ready` handshake, and signals frame completion so the frame can be replayed.

---
 rtl/vector_list_player.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vector_list_player.sv
// Display-list sequencer: fetches 32-bit vector commands from a synchronous RAM and hands them to
// the vector control block with a ready/guard handshake. Optional DWELL timing under VLP_DWELL_EN.
module vector_list_player #(
  parameter int ADDR_WIDTH   = 10,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  input  logic [31:0]           i_mem_data,
  output logic [11:0]           o_x,
  output logic [11:0]           o_y,
  output logic                  o_jump,
  output logic                  o_draw,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_ISSUE, S_GUARD, S_DWELL
  } state_t;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;

  state_t                r_state, w_next, w_adv_target;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [31:0]           r_cmd;
  logic [11:0]           r_x, r_y;
  logic [3:0]            r_guard, w_guard_next;
  logic                  r_frame_done, w_frame_done_next;
  logic                  w_advance, w_fire;
  logic [1:0]            w_op;
  logic                  w_unused;

`ifdef VLP_DWELL_EN
  logic [15:0]           r_dwell, w_dwell_next;
`endif

  assign w_op     = r_cmd[31:30];
  assign w_fire   = (r_state == S_ISSUE) && i_ready;
  assign w_unused = &{1'b0, r_cmd[29:24]};

  always_comb begin
    w_next            = r_state;
    w_pc_next         = r_pc;
    w_guard_next      = r_guard;
    w_frame_done_next = 1'b0;
    w_advance         = 1'b0;
    w_adv_target      = S_FETCH;
`ifdef VLP_DWELL_EN
    w_dwell_next      = r_dwell;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_next    = S_FETCH;
          w_pc_next = '0;
        end
      end
      S_FETCH:  w_next = i_stop ? S_IDLE : S_LATCH;
      S_LATCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_JUMP || w_op == OP_DRAW) begin
          w_next = S_ISSUE;
        end else if (w_op == OP_END) begin
          w_next            = S_IDLE;
          w_frame_done_next = 1'b1;
        end else begin
`ifdef VLP_DWELL_EN
          if (r_cmd[15:0] != 16'd0) begin
            w_next       = S_DWELL;
            w_dwell_next = r_cmd[15:0];
          end else begin
            w_advance = 1'b1;
          end
`else
          w_advance = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        if (i_ready) begin
          w_advance    = 1'b1;
          w_adv_target = S_GUARD;
          w_guard_next = 4'(GUARD_CYCLES - 1);
        end
      end
      S_GUARD: begin
        if (r_guard == 4'd0) w_next = S_FETCH;
        else                 w_guard_next = r_guard - 4'd1;
      end
`ifdef VLP_DWELL_EN
      S_DWELL: begin
        if (i_stop) begin
          w_next = S_IDLE;
        end else if (r_dwell == 16'd1) begin
          w_advance = 1'b1;
        end else begin
          w_dwell_next = r_dwell - 16'd1;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase

    // Running off the end of the list without an END acts as an implicit END.
    if (w_advance) begin
      if (&r_pc) begin
        w_pc_next         = '0;
        w_next            = S_IDLE;
        w_frame_done_next = 1'b1;
      end else begin
        w_pc_next = r_pc + 1'b1;
        w_next    = w_adv_target;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_cmd        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_guard      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_pc         <= w_pc_next;
      r_guard      <= w_guard_next;
      r_frame_done <= w_frame_done_next;
      if (r_state == S_LATCH) r_cmd <= i_mem_data;
      if (w_fire) begin
        r_x <= r_cmd[23:12];
        r_y <= r_cmd[11:0];
      end
    end
  end

`ifdef VLP_DWELL_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) r_dwell <= '0;
    else         r_dwell <= w_dwell_next;
  end
`endif

  // Coordinates are forwarded combinationally so they change in the same cycle as the pulse.
  assign o_mem_addr   = r_pc;
  assign o_mem_en     = (r_state == S_FETCH) && !i_stop;
  assign o_jump       = w_fire && (w_op == OP_JUMP);
  assign o_draw       = w_fire && (w_op == OP_DRAW);
  assign o_x          = w_fire ? r_cmd[23:12] : r_x;
  assign o_y          = w_fire ? r_cmd[11:0]  : r_y;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

endmodule
